reg_select_pipe: RTL

REG_SELECT_PIPE -- requirements
Module: reg_select_pipe

---
 rtl/reg_select_pipe.sv | 133 +++++++++++++
 1 files changed

// File: rtl/reg_select_pipe.sv
// Register-select decode with a one-entry registered output stage and an optional
// pending-write scoreboard (enabled by defining REG_SELECT_SCOREBOARD_EN).
module reg_select_pipe #(
  parameter int REG_ADDR_W = 4,
  parameter int IR_W       = 32,
  parameter int RA_LSB     = 23,
  parameter int RB_LSB     = 19,
  parameter int RC_LSB     = 15,
  parameter int C_W        = 19
) (
  input  logic                         clock,
  input  logic                         clear_n,
  input  logic                         ir_valid,
  output logic                         ir_ready,
  input  logic [IR_W-1:0]              IR_Data,
  input  logic                         Gra,
  input  logic                         Grb,
  input  logic                         Grc,
  input  logic                         Rin,
  input  logic                         Rout,
  input  logic                         BAout,
  input  logic                         wb_valid,
  input  logic [REG_ADDR_W-1:0]        wb_addr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [(2**REG_ADDR_W)-1:0]   RXin,
  output logic [(2**REG_ADDR_W)-1:0]   RXout,
  output logic [REG_ADDR_W-1:0]        R_sel,
  output logic [IR_W-1:0]              C_sign_extended,
  output logic [(2**REG_ADDR_W)-1:0]   busy
);

  localparam int NREG = 2**REG_ADDR_W;

  function automatic logic [NREG-1:0] onehot(input logic [REG_ADDR_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  function automatic logic [IR_W-1:0] sign_extend(input logic [IR_W-1:0] ir);
    logic signed [C_W-1:0]  imm;
    logic signed [IR_W-1:0] wide;
    imm  = ir[C_W-1:0];
    wide = imm;
    return wide;
  endfunction

  // ---- stage p0: field decode, read qualification, hazard ----
  logic [REG_ADDR_W-1:0] ra_p0, rb_p0, rc_p0, sel_p0;
  logic                  rd_en_p0;
  logic                  hazard_p0;
  logic                  accept_p0;
  logic                  vld_p1;

  assign ra_p0 = IR_Data[RA_LSB +: REG_ADDR_W];
  assign rb_p0 = IR_Data[RB_LSB +: REG_ADDR_W];
  assign rc_p0 = IR_Data[RC_LSB +: REG_ADDR_W];

  always_comb begin
    sel_p0 = '0;
    if (Gra)      sel_p0 = ra_p0;
    else if (Grb) sel_p0 = rb_p0;
    else if (Grc) sel_p0 = rc_p0;
  end

  // A base-address read of R0 is a constant zero, so it drives no enable and never stalls.
  assign rd_en_p0  = Rout | (BAout & (sel_p0 != '0));
  assign ir_ready  = (~vld_p1 | out_ready) & ~hazard_p0;
  assign accept_p0 = ir_valid & ir_ready;

`ifdef REG_SELECT_SCOREBOARD_EN
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_nxt;
  logic            wb_hit_p0;

  // A write-back landing this cycle on the register being read bypasses the stall.
  assign wb_hit_p0 = wb_valid & (wb_addr == sel_p0);
  assign hazard_p0 = rd_en_p0 & busy_q[sel_p0] & ~wb_hit_p0;

  always_comb begin
    busy_nxt = busy_q;
    if (wb_valid)
      busy_nxt[wb_addr] = 1'b0;
    if (accept_p0 && Rin)
      busy_nxt[sel_p0] = 1'b1;
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) busy_q <= '0;
    else          busy_q <= busy_nxt;
  end

  assign busy = busy_q;
`else
  assign hazard_p0 = 1'b0;
  assign busy      = '0;
`endif

  // Some instruction bits are not decoded; write-back is unused without the scoreboard.
  logic unused_ok;
  assign unused_ok = ^{IR_Data, wb_valid, wb_addr};

  // ---- stage p1: one-entry output register ----
  logic [NREG-1:0]       rxin_p1;
  logic [NREG-1:0]       rxout_p1;
  logic [REG_ADDR_W-1:0] sel_p1;
  logic [IR_W-1:0]       c_p1;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      vld_p1   <= 1'b0;
      rxin_p1  <= '0;
      rxout_p1 <= '0;
      sel_p1   <= '0;
      c_p1     <= '0;
    end else if (accept_p0) begin
      vld_p1   <= 1'b1;
      rxin_p1  <= Rin      ? onehot(sel_p0) : '0;
      rxout_p1 <= rd_en_p0 ? onehot(sel_p0) : '0;
      sel_p1   <= sel_p0;
      c_p1     <= sign_extend(IR_Data);
    end else if (out_ready) begin
      vld_p1   <= 1'b0;
    end
  end

  assign out_valid       = vld_p1;
  assign RXin            = rxin_p1;
  assign RXout           = rxout_p1;
  assign R_sel           = sel_p1;
  assign C_sign_extended = c_p1;

endmodule
